// File: rtl/stack_unit.sv
// Parametrised hardware stack with registered top-of-stack, a pop-data strobe,
// full/empty status and sticky overflow/underflow flags.
module stack_unit #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int SP_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              ld_sp,
    input  logic [SP_W-1:0]   sp_in,
    input  logic [DATA_W-1:0] din,
    input  logic              clr_err,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [DATA_W-1:0] top,
    output logic [SP_W-1:0]   sp,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              udf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [SP_W-1:0] DEPTH_SP = SP_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [SP_W-1:0]   sp_q, sp_d, ldSp;
    logic [DATA_W-1:0] top_q, top_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic              pop_valid_q, pop_valid_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              memWe;
    logic [AW-1:0]     memWAddr;

    assign full  = (sp_q == DEPTH_SP);
    assign empty = (sp_q == '0);

    always_comb begin
        sp_d        = sp_q;
        top_d       = top_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        ovf_d       = ovf_q;
        udf_d       = udf_q;
        memWe       = 1'b0;
        memWAddr    = AW'(sp_q);
        ldSp        = (sp_in > DEPTH_SP) ? DEPTH_SP : sp_in;

        // Clear first so that an error event later in this cycle takes precedence.
        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end

        if (ld_sp) begin
            sp_d = ldSp;
            if (sp_in > DEPTH_SP) begin
                ovf_d = 1'b1;
            end
            top_d = (ldSp == '0) ? '0 : mem[AW'(ldSp - SP_W'(1))];
        end else if (push && pop && !empty) begin
            memWe       = 1'b1;
            memWAddr    = AW'(sp_q - SP_W'(1));
            pop_data_d  = top_q;
            pop_valid_d = 1'b1;
            top_d       = din;
        end else if (push) begin
            if (!full) begin
                memWe = 1'b1;
                sp_d  = sp_q + SP_W'(1);
                top_d = din;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (pop) begin
            if (!empty) begin
                pop_data_d  = mem[AW'(sp_q - SP_W'(1))];
                pop_valid_d = 1'b1;
                sp_d        = sp_q - SP_W'(1);
                top_d       = (sp_q == SP_W'(1)) ? '0 : mem[AW'(sp_q - SP_W'(2))];
            end else begin
                udf_d = 1'b1;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memWAddr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q        <= '0;
            top_q       <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            top_q       <= top_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    assign sp        = sp_q;
    assign top       = top_q;
    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
    assign ovf       = ovf_q;
    assign udf       = udf_q;

endmodule
